// File: rtl/sfpga_link_if.sv
// sfpga_link_if -- request/ready handshake of the master/slave FPGA board link.
//   m_rd_req : master -> slave, level read request
//   m_wr_req : master -> slave, level write request
//   s_ready  : slave -> master, registered ready
// The shared data_ov/data_out bus is bidirectional and stays a plain inout
// pair on the endpoint so the tristate resolves on board-level nets.
interface sfpga_link_if;
  logic m_rd_req;
  logic m_wr_req;
  logic s_ready;

  modport master (output m_rd_req, output m_wr_req, input s_ready);
  modport slave  (input m_rd_req, input m_wr_req, output s_ready);
endinterface

// File: rtl/sfpga_link.sv
// sfpga_link -- slave-side endpoint of the master-driven board link.
// Read bursts stream words from a local TX FIFO onto the shared bus after a
// one-cycle turnaround; write bursts capture master words into a local RX FIFO.
// Ports:
//   clk, reset         : link clock, asynchronous active-low reset
//   lnk (slave)        : m_rd_req / m_wr_req in, s_ready out (registered)
//   data_ov, data_out  : shared bus, driven only while the slave owns it
//   tx_push/tx_data    : local TX FIFO write, tx_full status
//   rx_pop/rx_data     : local RX FIFO read (first-word-fall-through)
//   rx_empty, rx_ovf   : RX status; rx_ovf is sticky until reset
module sfpga_link #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  sfpga_link_if.slave           lnk,
  inout  wire                   data_ov,
  inout  wire  [DATA_WIDTH-1:0] data_out,
  input  logic                  tx_push,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_full,
  input  logic                  rx_pop,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_empty,
  output logic                  rx_ovf
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_READY = (ADDR_WIDTH+1)'(DEPTH - 2);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [15:0]           BURST_MAX = 16'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TURN = 3'd1,
    S_SEND = 3'd2,
    S_END  = 3'd3,
    S_RECV = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  oe_q, oe_d;
  logic                  ov_q, ov_d;
  logic                  s_ready_q, s_ready_d;
  logic                  rx_ovf_q, rx_ovf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [15:0]           cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] tx_wp_q, tx_rp_q;
  logic [ADDR_WIDTH:0]   tx_cnt_q, tx_cnt_nxt_s;
  logic                  tx_wr_s, tx_pop_s, tx_empty_s;

  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rx_wp_q, rx_rp_q;
  logic [ADDR_WIDTH:0]   rx_cnt_q, rx_cnt_nxt_s;
  logic                  rx_wr_s, rx_rd_s, rx_full_s, ovf_evt_s, send_ok_s;

  // Bus is released the moment oe drops, including asynchronously on reset.
  assign data_ov     = oe_q ? ov_q : 1'bz;
  assign data_out    = oe_q ? dout_q : {DATA_WIDTH{1'bz}};
  assign lnk.s_ready = s_ready_q;
  assign rx_ovf      = rx_ovf_q;

  assign tx_empty_s = (tx_cnt_q == '0);
  assign tx_full    = (tx_cnt_q == CNT_FULL);
  assign tx_wr_s    = tx_push && !tx_full;
  assign rx_empty   = (rx_cnt_q == '0);
  assign rx_full_s  = (rx_cnt_q == CNT_FULL);
  assign rx_data    = rx_mem[rx_rp_q];
  assign rx_rd_s    = rx_pop && !rx_empty;
  // Master words only count while in RECV and only when ready was advertised.
  assign rx_wr_s    = (state_q == S_RECV) && data_ov && s_ready_q && !rx_full_s;
  assign ovf_evt_s  = (state_q == S_RECV) && data_ov && s_ready_q && rx_full_s;
  assign send_ok_s  = lnk.m_rd_req && !tx_empty_s && (cnt_q < BURST_MAX);

  // FIFO occupancy after this edge's push/pop.
  always_comb begin
    tx_cnt_nxt_s = tx_cnt_q;
    rx_cnt_nxt_s = rx_cnt_q;
    case ({tx_wr_s, tx_pop_s})
      2'b10:   tx_cnt_nxt_s = tx_cnt_q + CNT_ONE;
      2'b01:   tx_cnt_nxt_s = tx_cnt_q - CNT_ONE;
      default: tx_cnt_nxt_s = tx_cnt_q;
    endcase
    case ({rx_wr_s, rx_rd_s})
      2'b10:   rx_cnt_nxt_s = rx_cnt_q + CNT_ONE;
      2'b01:   rx_cnt_nxt_s = rx_cnt_q - CNT_ONE;
      default: rx_cnt_nxt_s = rx_cnt_q;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (tx_wr_s) tx_mem[tx_wp_q] <= tx_data;
    if (rx_wr_s) rx_mem[rx_wp_q] <= data_out;
  end

  // FIFO pointers and counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_wr_s)  tx_wp_q <= tx_wp_q + PTR_ONE;
      if (tx_pop_s) tx_rp_q <= tx_rp_q + PTR_ONE;
      if (rx_wr_s)  rx_wp_q <= rx_wp_q + PTR_ONE;
      if (rx_rd_s)  rx_rp_q <= rx_rp_q + PTR_ONE;
      tx_cnt_q <= tx_cnt_nxt_s;
      rx_cnt_q <= rx_cnt_nxt_s;
    end
  end

  // Link state machine: next state and the registered bus/handshake values.
  // Outputs are computed for the state being entered, so TURN->SEND already
  // registers the first word and END->IDLE releases the bus.
  always_comb begin
    state_d   = state_q;
    oe_d      = oe_q;
    ov_d      = 1'b0;
    dout_d    = dout_q;
    s_ready_d = 1'b0;
    cnt_d     = cnt_q;
    tx_pop_s  = 1'b0;
    rx_ovf_d  = rx_ovf_q | ovf_evt_s;
    case (state_q)
      S_IDLE: begin
        if (lnk.m_rd_req) begin
          state_d = S_TURN;
          oe_d    = 1'b1;
          cnt_d   = 16'd0;
        end else if (lnk.m_wr_req) begin
          state_d   = S_RECV;
          oe_d      = 1'b0;
          s_ready_d = (rx_cnt_nxt_s <= CNT_READY);
        end else begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
        end
      end
      S_TURN, S_SEND: begin
        oe_d = 1'b1;
        // Leaving SEND: request dropped or burst cap already reached.
        if ((state_q == S_SEND) && (!lnk.m_rd_req || (cnt_q == BURST_MAX))) begin
          state_d = S_END;
        end else begin
          state_d   = S_SEND;
          s_ready_d = 1'b1;
          if (send_ok_s) begin
            tx_pop_s = 1'b1;
            dout_d   = tx_mem[tx_rp_q];
            ov_d     = 1'b1;
            cnt_d    = cnt_q + 16'd1;
          end else begin
            dout_d = dout_q;
          end
        end
      end
      S_END: begin
        state_d = S_IDLE;
        oe_d    = 1'b0;
      end
      S_RECV: begin
        oe_d = 1'b0;
        if (!lnk.m_wr_req) begin
          state_d = S_IDLE;
        end else begin
          // Ready one entry early so a word already in flight still fits.
          s_ready_d = (rx_cnt_nxt_s <= CNT_READY);
        end
      end
      default: begin
        state_d = S_IDLE;
        oe_d    = 1'b0;
      end
    endcase
  end

  // Link state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      oe_q      <= 1'b0;
      ov_q      <= 1'b0;
      dout_q    <= '0;
      s_ready_q <= 1'b0;
      rx_ovf_q  <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      oe_q      <= oe_d;
      ov_q      <= ov_d;
      dout_q    <= dout_d;
      s_ready_q <= s_ready_d;
      rx_ovf_q  <= rx_ovf_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sfpga_link.sv
// tb_sfpga_link -- directed bench for sfpga_link.
// Instance a (depth 16, burst cap 8) covers reads, burst cap, early stop,
// arbitration and async reset; instance b (depth 4) covers write backpressure
// and overflow. Pull-ups on the shared nets make a released bus read as ones.
module tb_sfpga_link;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sfpga_link_if lnk_a ();
  sfpga_link_if lnk_b ();

  wire          a_ov;
  wire [DW-1:0] a_dout;
  pullup (a_ov);
  pullup (a_dout);

  wire          b_ov;
  wire [DW-1:0] b_dout;
  logic         m_drv, m_ov_v;
  logic [DW-1:0] m_dat;
  assign b_ov   = m_drv ? m_ov_v : 1'bz;
  assign b_dout = m_drv ? m_dat : {DW{1'bz}};

  logic          tx_push_a, tx_full_a, rx_pop_a, rx_empty_a, rx_ovf_a;
  logic [DW-1:0] tx_data_a, rx_data_a;
  logic          tx_push_b, tx_full_b, rx_pop_b, rx_empty_b, rx_ovf_b;
  logic [DW-1:0] tx_data_b, rx_data_b;

  sfpga_link #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .BURST_LEN(8)) dut_a (
    .clk(clk), .reset(reset), .lnk(lnk_a), .data_ov(a_ov), .data_out(a_dout),
    .tx_push(tx_push_a), .tx_data(tx_data_a), .tx_full(tx_full_a),
    .rx_pop(rx_pop_a), .rx_data(rx_data_a), .rx_empty(rx_empty_a), .rx_ovf(rx_ovf_a)
  );

  sfpga_link #(.DATA_WIDTH(DW), .ADDR_WIDTH(2), .BURST_LEN(8)) dut_b (
    .clk(clk), .reset(reset), .lnk(lnk_b), .data_ov(b_ov), .data_out(b_dout),
    .tx_push(tx_push_b), .tx_data(tx_data_b), .tx_full(tx_full_b),
    .rx_pop(rx_pop_b), .rx_data(rx_data_b), .rx_empty(rx_empty_b), .rx_ovf(rx_ovf_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] txq [$];
  logic [DW-1:0] rxq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [DW-1:0] v);
    tx_push_a = 1'b1;
    tx_data_a = v;
    txq.push_back(v);
    tick();
    tx_push_a = 1'b0;
  endtask

  task automatic expect_word(input string tag);
    logic [DW-1:0] e;
    e = txq.pop_front();
    tick();
    check({tag, "_ov"}, {31'd0, a_ov}, 32'd1);
    check({tag, "_rdy"}, {31'd0, lnk_a.s_ready}, 32'd1);
    check({tag, "_data"}, {16'd0, a_dout}, {16'd0, e});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ov_z"}, {31'd0, a_ov}, 32'd1);
    check({tag, "_dout_z"}, {16'd0, a_dout}, 32'h0000_FFFF);
    check({tag, "_rdy"}, {31'd0, lnk_a.s_ready}, 32'd0);
  endtask

  // Full read: request, turnaround, n words, empty hold, drop, END, IDLE.
  task automatic burst_and_drain(input string tag, input int n);
    lnk_a.m_rd_req = 1'b1;
    tick();
    check({tag, "_turn_ov"}, {31'd0, a_ov}, 32'd0);
    check({tag, "_turn_rdy"}, {31'd0, lnk_a.s_ready}, 32'd0);
    for (int i = 0; i < n; i++) expect_word(tag);
    tick();
    check({tag, "_empty_ov"}, {31'd0, a_ov}, 32'd0);
    check({tag, "_empty_rdy"}, {31'd0, lnk_a.s_ready}, 32'd1);
    lnk_a.m_rd_req = 1'b0;
    tick();
    check({tag, "_end_ov"}, {31'd0, a_ov}, 32'd0);
    check({tag, "_end_rdy"}, {31'd0, lnk_a.s_ready}, 32'd0);
    tick();
    check_idle({tag, "_idle"});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic r;
    int   widx;
    reset = 1'b0;
    lnk_a.m_rd_req = 1'b0; lnk_a.m_wr_req = 1'b0;
    lnk_b.m_rd_req = 1'b0; lnk_b.m_wr_req = 1'b0;
    tx_push_a = 1'b0; tx_data_a = '0; rx_pop_a = 1'b0;
    tx_push_b = 1'b0; tx_data_b = '0; rx_pop_b = 1'b0;
    m_drv = 1'b0; m_ov_v = 1'b0; m_dat = '0;

    // Reset held with requests toggling.
    for (int i = 0; i < 3; i++) begin
      lnk_a.m_rd_req = i[0];
      lnk_a.m_wr_req = ~i[0];
      tick();
      check_idle("rst_hold");
      check("rst_rx_empty", {31'd0, rx_empty_a}, 32'd1);
      check("rst_tx_full", {31'd0, tx_full_a}, 32'd0);
      check("rst_ovf", {31'd0, rx_ovf_a}, 32'd0);
    end
    lnk_a.m_rd_req = 1'b0; lnk_a.m_wr_req = 1'b0;
    reset = 1'b1;
    tick();

    // Read latency: four words in order, then hold empty.
    for (int i = 0; i < 4; i++) push_tx(16'h00A0 + 16'(i));
    check("pre_tx_full", {31'd0, tx_full_a}, 32'd0);
    burst_and_drain("lat", 4);

    // Burst cap of 8 out of 12, then the remaining 4.
    for (int i = 0; i < 12; i++) push_tx(16'h00B0 + 16'(i));
    lnk_a.m_rd_req = 1'b1;
    tick();
    check("cap_turn_ov", {31'd0, a_ov}, 32'd0);
    for (int i = 0; i < 8; i++) expect_word("cap");
    tick();
    check("cap_end_ov", {31'd0, a_ov}, 32'd0);
    check("cap_end_rdy", {31'd0, lnk_a.s_ready}, 32'd0);
    lnk_a.m_rd_req = 1'b0;
    tick();
    check_idle("cap_idle");
    burst_and_drain("rem", 4);

    // Early stop after one word, later request sends the other.
    push_tx(16'h00C0);
    push_tx(16'h00C1);
    lnk_a.m_rd_req = 1'b1;
    tick();
    expect_word("early");
    lnk_a.m_rd_req = 1'b0;
    tick();
    check("early_end_ov", {31'd0, a_ov}, 32'd0);
    check("early_end_rdy", {31'd0, lnk_a.s_ready}, 32'd0);
    tick();
    check_idle("early_idle");
    burst_and_drain("refill", 1);

    // Write backpressure on the depth-4 instance.
    m_drv = 1'b1; m_ov_v = 1'b1; widx = 0; m_dat = 16'h0100;
    lnk_b.m_wr_req = 1'b1;
    for (int c = 0; c < 20 && widx < 3; c++) begin
      r = lnk_b.s_ready;
      tick();
      if (r) begin
        rxq.push_back(m_dat);
        widx++;
        m_dat = 16'h0100 + 16'(widx);
      end
    end
    check("bp_stored", widx, 32'd3);
    check("bp_ready_low", {31'd0, lnk_b.s_ready}, 32'd0);
    check("bp_head", {16'd0, rx_data_b}, 32'h0000_0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_rdy", {31'd0, lnk_b.s_ready}, 32'd0);
      check("bp_hold_ovf", {31'd0, rx_ovf_b}, 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      check("bp_pop_data", {16'd0, rx_data_b}, {16'd0, rxq.pop_front()});
      rx_pop_b = 1'b1;
      tick();
      rx_pop_b = 1'b0;
      check("bp_resume_rdy", {31'd0, lnk_b.s_ready}, 32'd1);
      tick();
      rxq.push_back(m_dat);
      widx++;
      m_dat = 16'h0100 + 16'(widx);
      check("bp_refill_rdy", {31'd0, lnk_b.s_ready}, 32'd0);
    end
    // Force ready to fill the last slot, then present a word while full.
    m_dat = 16'h01AA;
    force dut_b.s_ready_q = 1'b1;
    tick();
    rxq.push_back(16'h01AA);
    m_dat = 16'h01BB;
    tick();
    m_ov_v = 1'b0;
    release dut_b.s_ready_q;
    check("ovf_set", {31'd0, rx_ovf_b}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", {16'd0, rx_data_b}, {16'd0, rxq.pop_front()});
      rx_pop_b = 1'b1;
      tick();
      rx_pop_b = 1'b0;
    end
    check("drain_empty", {31'd0, rx_empty_b}, 32'd1);
    check("ovf_sticky", {31'd0, rx_ovf_b}, 32'd1);
    lnk_b.m_wr_req = 1'b0;
    tick();
    check("wr_exit_rdy", {31'd0, lnk_b.s_ready}, 32'd0);
    m_drv = 1'b0;

    // Arbitration: both requests together go to a read.
    push_tx(16'h00D0);
    push_tx(16'h00D1);
    lnk_a.m_rd_req = 1'b1;
    lnk_a.m_wr_req = 1'b1;
    tick();
    check("arb_turn_ov", {31'd0, a_ov}, 32'd0);
    check("arb_turn_rdy", {31'd0, lnk_a.s_ready}, 32'd0);
    expect_word("arb");
    // Asynchronous reset mid-word releases the bus immediately.
    #3;
    reset = 1'b0;
    #1;
    check_idle("arst");
    check("arst_tx_full", {31'd0, tx_full_a}, 32'd0);
    check("arst_rx_empty", {31'd0, rx_empty_a}, 32'd1);
    check("arst_ovf_b", {31'd0, rx_ovf_b}, 32'd0);
    txq.delete();
    lnk_a.m_rd_req = 1'b0;
    lnk_a.m_wr_req = 1'b0;
    reset = 1'b1;
    tick();
    // TX FIFO was flushed: a new read finds nothing to send.
    burst_and_drain("post_rst", 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
